// File: rtl/block_refill.sv
// block_refill: line refill engine in front of the cache data block.
// On an accepted miss it optionally writes the dirty victim back to memory one
// word at a time. It then reads the missing line word by word into a wide line
// register, and strobes new_block for one cycle when the line is complete. The
// missed (critical) word is forwarded early on crit_valid/crit_data.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   miss_valid/miss_ready     miss handshake (ready only while idle)
//   miss_line, miss_offset    line to fetch, word the CPU is waiting on
//   victim_dirty/line/data    victim writeback request and contents
//   mem_req/we/addr/wdata     word memory request, held until mem_ack
//   mem_ack, mem_rdata        word transfer completion, read data
//   w_block_data, new_block   assembled line and its completion strobe
//   crit_valid, crit_data     early critical-word forward
//   busy                      engine not idle

// One line lane: loads on its own fill ack, otherwise holds.
module block_refill_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module block_refill #(
    parameter int BLCK_ADDR    = 4,
    parameter int NUM_OF_WORDS = 16,
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              miss_valid,
    output logic                              miss_ready,
    input  logic [ADDR_WIDTH-BLCK_ADDR-1:0]   miss_line,
    input  logic [BLCK_ADDR-1:0]              miss_offset,
    input  logic                              victim_dirty,
    input  logic [ADDR_WIDTH-BLCK_ADDR-1:0]   victim_line,
    input  logic [WORD_SIZE*NUM_OF_WORDS-1:0] victim_data,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [WORD_SIZE-1:0]              mem_wdata,
    input  logic                              mem_ack,
    input  logic [WORD_SIZE-1:0]              mem_rdata,
    output logic [WORD_SIZE*NUM_OF_WORDS-1:0] w_block_data,
    output logic                              new_block,
    output logic                              crit_valid,
    output logic [WORD_SIZE-1:0]              crit_data,
    output logic                              busy
);
    localparam int LINE_W = ADDR_WIDTH - BLCK_ADDR;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    typedef struct packed {
        logic [LINE_W-1:0]    line;
        logic [BLCK_ADDR-1:0] offset;
        logic [LINE_W-1:0]    vline;
    } req_t;

    state_t                                   state, state_nx;
    logic [BLCK_ADDR-1:0]                     cnt;
    req_t                                     req_q;
    logic [NUM_OF_WORDS-1:0][WORD_SIZE-1:0]   vdata_q;
    logic [NUM_OF_WORDS-1:0][WORD_SIZE-1:0]   lanes;
    logic [NUM_OF_WORDS-1:0]                  lane_we;
    logic                                     last;
    logic                                     fill_ack;

    assign last       = (cnt == BLCK_ADDR'(NUM_OF_WORDS - 1));
    assign fill_ack   = (state == FILL) && mem_ack;
    assign miss_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign new_block  = (state == DONE);

    // Memory request is decoded from state/cnt, so it is inherently stable
    // while stalled and drops to zero the moment reset returns us to IDLE.
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: if (miss_valid) state_nx = victim_dirty ? WB : FILL;
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {req_q.vline, cnt};
                mem_wdata = vdata_q[cnt];
                if (mem_ack && last) state_nx = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_q.line, cnt};
                if (mem_ack && last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_q      <= '0;
            vdata_q    <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            state <= state_nx;
            // Word counter restarts on every state entry.
            if (state_nx != state)
                cnt <= '0;
            else if (mem_ack && (state == WB || state == FILL))
                cnt <= cnt + 1'b1;
            if (state == IDLE && miss_valid) begin
                req_q   <= '{line: miss_line, offset: miss_offset, vline: victim_line};
                vdata_q <= victim_data;
            end
            crit_valid <= fill_ack && (cnt == req_q.offset);
            if (fill_ack && (cnt == req_q.offset))
                crit_data <= mem_rdata;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OF_WORDS; g++) begin : g_lane
            assign lane_we[g] = fill_ack && (cnt == BLCK_ADDR'(g));
            block_refill_lane #(.W(WORD_SIZE)) u_lane (
                .clk (clk),
                .rst (rst),
                .we  (lane_we[g]),
                .d   (mem_rdata),
                .q   (lanes[g])
            );
        end
    endgenerate

    assign w_block_data = lanes;
endmodule

// File: tb/tb_block_refill.sv
module tb_block_refill;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_valid = 1'b0, miss_ready;
    logic [11:0]  miss_line = '0;
    logic [3:0]   miss_offset = '0;
    logic         victim_dirty = 1'b0;
    logic [11:0]  victim_line = '0;
    logic [255:0] victim_data = '0;
    logic         mem_req, mem_we, mem_ack = 1'b0;
    logic [15:0]  mem_addr, mem_wdata, mem_rdata;
    logic [255:0] w_block_data;
    logic         new_block, crit_valid, busy;
    logic [15:0]  crit_data;

    block_refill dut (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_line(miss_line), .miss_offset(miss_offset), .victim_dirty(victim_dirty),
        .victim_line(victim_line), .victim_data(victim_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .w_block_data(w_block_data), .new_block(new_block),
        .crit_valid(crit_valid), .crit_data(crit_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5AC3;
    endfunction

    assign mem_rdata = model(mem_addr);

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    txn_t         mem_q[$];
    logic [255:0] line_q[$];
    logic [15:0]  crit_q[$];
    int           errors = 0, checks = 0;
    int           cyc = 0, acc = 0, crit_cyc = 0;
    bit           rand_ack = 1'b0;
    logic [255:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder + scoreboard monitor, all at negedge.
    txn_t exp_t, prev;
    bit   prev_stall = 1'b0;
    int   stall = 0;
    logic [255:0] exp_line;
    logic [15:0]  exp_crit;

    always @(negedge clk) begin
        if (!rand_ack) mem_ack = 1'b1;
        else if (stall > 0) begin mem_ack = 1'b0; stall--; end
        else begin mem_ack = 1'b1; stall = $urandom_range(0, 3); end

        if (rst) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("stall_req_held", mem_req, 1'b1);
                chk("stall_bus_held", {mem_we, mem_addr, mem_wdata}, prev);
            end
            prev_stall = mem_req && !mem_ack;
            prev       = {mem_we, mem_addr, mem_wdata};
            if (mem_req && mem_ack) begin
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_txn: got addr %0h expected none", mem_addr);
                end else begin
                    exp_t = mem_q.pop_front();
                    chk("mem_we", mem_we, exp_t.we);
                    chk("mem_addr", mem_addr, exp_t.addr);
                    if (exp_t.we) chk("mem_wdata", mem_wdata, exp_t.wdata);
                end
            end
            if (crit_valid) begin
                crit_cyc = cyc;
                if (crit_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_crit: got %0h expected none", crit_data);
                end else begin
                    exp_crit = crit_q.pop_front();
                    chk("crit_data", crit_data, exp_crit);
                end
            end
            if (new_block) begin
                if (line_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_new_block: got line %0h expected none", w_block_data);
                end else begin
                    exp_line = line_q.pop_front();
                    chk("line_data", w_block_data, exp_line);
                end
            end
        end
    end

    // Issue a miss at posedge+#1 with the engine idle; returns one cycle later.
    task automatic start_miss(input logic [11:0] line, input logic [3:0] off, input bit dirty,
                              input logic [11:0] vline, input logic [255:0] vdata);
        logic [255:0] exp;
        chk("miss_ready_idle", miss_ready, 1'b1);
        miss_valid = 1'b1; miss_line = line; miss_offset = off;
        victim_dirty = dirty; victim_line = vline; victim_data = vdata;
        if (dirty)
            for (int j = 0; j < N; j++)
                mem_q.push_back({1'b1, vline, 4'(j), vdata[j*16 +: 16]});
        for (int j = 0; j < N; j++) begin
            mem_q.push_back({1'b0, line, 4'(j), 16'h0});
            exp[j*16 +: 16] = model({line, 4'(j)});
        end
        line_q.push_back(exp);
        crit_q.push_back(model({line, off}));
        last_exp = exp;
        @(posedge clk); #1;
        acc = cyc;
        miss_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        bit seen = 1'b0;
        int lat  = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = new_block;
            lat  = cyc - acc + 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL new_block_timeout: got none expected strobe");
            mem_q.delete(); line_q.delete(); crit_q.delete();
        end else if (exp_lat != 0) chk("new_block_cycle", lat, exp_lat);
        @(posedge clk); #1;
        chk("scoreboard_drained", {mem_q.size(), line_q.size(), crit_q.size()}, 0);
        chk("line_held", w_block_data, last_exp);
        chk("new_block_one_cycle", new_block, 1'b0);
    endtask

    logic [255:0] vd;
    bit           nb_seen;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_state", {mem_req, mem_we, mem_addr, mem_wdata, new_block, crit_valid, crit_data, busy}, 0);
        chk("rst_line", w_block_data, 0);
        chk("rst_ready", miss_ready, 1'b1);

        // 1: clean miss, critical word 5, ack tied high
        start_miss(12'h012, 4'd5, 1'b0, 12'h000, '0);
        wait_done(17);
        chk("crit_cycle", crit_cyc - acc + 1, 7);

        // 2: dirty miss with writeback
        for (int j = 0; j < N; j++) vd[j*16 +: 16] = 16'hA000 + 16'(j);
        start_miss(12'h0CD, 4'd2, 1'b1, 12'h0AB, vd);
        wait_done(33);

        // 3: random memory stalls
        rand_ack = 1'b1;
        for (int j = 0; j < N; j++) vd[j*16 +: 16] = 16'hBEEF ^ (16'h1111 * 16'(j));
        start_miss(12'h1C3, 4'd9, 1'b1, 12'h2D0, vd);
        wait_done(0);
        start_miss(12'h3E7, 4'd12, 1'b0, 12'h000, '0);
        wait_done(0);
        rand_ack = 1'b0;

        // 4: miss pulsed during FILL is ignored
        start_miss(12'h034, 4'd3, 1'b0, 12'h000, '0);
        repeat (4) @(posedge clk); #1;
        chk("busy_in_fill", {busy, miss_ready}, 2'b10);
        miss_valid = 1'b1; miss_line = 12'h0FF; victim_dirty = 1'b1; victim_line = 12'h777;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        wait_done(17);

        // 5: reset in the middle of FILL
        start_miss(12'h055, 4'd10, 1'b0, 12'h000, '0);
        repeat (7) @(posedge clk); #1;
        chk("fill_word7", mem_addr, 16'h0557);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", {mem_req, mem_we, mem_addr, mem_wdata, new_block, crit_valid, crit_data, busy}, 0);
        chk("abort_line", w_block_data, 0);
        chk("abort_ready", miss_ready, 1'b1);
        mem_q.delete(); line_q.delete(); crit_q.delete();
        nb_seen = 1'b0;
        repeat (20) begin @(negedge clk); nb_seen |= new_block; end
        chk("abort_no_new_block", nb_seen, 1'b0);
        @(posedge clk); #1;
        start_miss(12'h066, 4'd1, 1'b0, 12'h000, '0);
        wait_done(17);

        // 6: boundary critical offsets
        start_miss(12'h0A0, 4'd0, 1'b0, 12'h000, '0);
        wait_done(17);
        chk("crit_cycle_off0", crit_cyc - acc + 1, 2);
        start_miss(12'h0B0, 4'd15, 1'b0, 12'h000, '0);
        wait_done(17);
        chk("crit_cycle_off15", crit_cyc - acc + 1, 17);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
